// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Desc     : Shared widths, frontend latency and fetch state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int c_IMEM_ADDR_WIDTH = 16;
    localparam int c_INSTR_WIDTH     = 32;
    localparam int c_IMEM_RD_LATENCY = 2;

    localparam logic [1:0] c_FETCH_IDLE = 2'd0;
    localparam logic [1:0] c_FETCH_RUN  = 2'd1;
    localparam logic [1:0] c_FETCH_HALT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Desc     : First-word-fall-through instruction buffer with synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_en;
    logic             w_pop_en;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_pop_en  = pop & ~empty;
    // A pop in the same cycle frees the slot, so push-while-full is fine then.
    assign w_push_en = push & (~full | w_pop_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_en) r_mem[r_wr_ptr] <= din;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush));

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Desc     : Sequential instruction fetch with credit-limited reads, redirect
//            discard of stale responses and a FWFT buffer toward decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W       = c_IMEM_ADDR_WIDTH,
    parameter int INSTR_W      = c_INSTR_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fe_ready,
    output logic [ADDR_W-1:0]  fe_addr,
    output logic               fe_valid,
    input  logic [INSTR_W-1:0] fe_data,
    input  logic               fe_rvalid,
    input  logic [ADDR_W-1:0]  fe_raddr,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               halt,
    output logic               fetch_busy
);

    localparam int          c_INF_W   = $clog2(MAX_INFLIGHT + 1);
    localparam int          c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int          c_ENTRY_W = INSTR_W + ADDR_W;
    localparam logic [31:0] c_DEPTH_U = FIFO_DEPTH;
    localparam logic [31:0] c_MAXI_U  = MAX_INFLIGHT;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_resp_pc;
    logic [c_INF_W-1:0]   r_inflight;
    logic [c_INF_W-1:0]   r_drop_cnt;
    logic                 w_issue;
    logic                 w_start;
    logic                 w_abort;
    logic                 w_redirect;
    logic                 w_credit;
    logic                 w_resp;
    logic                 w_dropping;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic [c_ENTRY_W-1:0] w_head;

    // Responses arriving with nothing tracked (stale after an abort) are ignored.
    assign w_resp     = fe_rvalid & (r_inflight != '0);
    assign w_dropping = (r_drop_cnt != '0);
    assign w_credit   = ((32'(r_inflight) + 32'(w_fifo_count)) < c_DEPTH_U) &&
                        (32'(r_inflight) < c_MAXI_U);
    assign w_push     = w_resp & ~w_dropping & ~w_redirect & ~w_abort;
    assign w_pop      = dec_ready & ~w_fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_FETCH_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_redirect  = 1'b0;
        case (r_state)
            c_FETCH_IDLE: begin
                if (fe_ready) begin
                    w_state_nxt = c_FETCH_RUN;
                    w_start     = 1'b1;
                end
            end
            c_FETCH_RUN: begin
                if (!fe_ready) begin
                    w_state_nxt = c_FETCH_IDLE;
                    w_abort     = 1'b1;
                end else if (redirect_valid) begin
                    w_redirect  = 1'b1;
                end else if (halt) begin
                    w_state_nxt = c_FETCH_HALT;
                end else begin
                    w_issue     = w_credit;
                end
            end
            c_FETCH_HALT: begin
                if (!fe_ready) w_state_nxt = c_FETCH_IDLE;
            end
            default: w_state_nxt = c_FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_resp_pc  <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else if (w_abort) begin
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_start) begin
                r_pc      <= '0;
                r_resp_pc <= '0;
            end else if (w_redirect) begin
                // Every read still outstanding after this cycle predates the jump.
                r_pc       <= redirect_addr;
                r_resp_pc  <= redirect_addr;
                r_drop_cnt <= r_inflight - c_INF_W'(w_resp);
            end else begin
                if (w_issue) r_pc      <= r_pc + ADDR_W'(1);
                if (w_push)  r_resp_pc <= r_resp_pc + ADDR_W'(1);
                if (w_resp && w_dropping) r_drop_cnt <= r_drop_cnt - c_INF_W'(1);
            end
            case ({w_issue, w_resp})
                2'b10:   r_inflight <= r_inflight + c_INF_W'(1);
                2'b01:   r_inflight <= r_inflight - c_INF_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_abort | w_redirect),
        .push  (w_push),
        .din   ({fe_data, r_resp_pc}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign fe_valid   = w_issue;
    assign fe_addr    = r_pc;
    assign dec_valid  = ~w_fifo_empty;
    assign dec_instr  = w_fifo_empty ? '0 : w_head[c_ENTRY_W-1 -: INSTR_W];
    assign dec_pc     = w_fifo_empty ? '0 : w_head[ADDR_W-1:0];
    assign fetch_busy = (r_inflight != '0) | ~w_fifo_empty;

    a_resp_addr: assert property (@(posedge clk) disable iff (rst)
        w_push |-> (fe_raddr == r_resp_pc));
    a_credit: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_fifo_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Desc     : Directed bench with frontend latency model and decode scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int AW  = 16;
    localparam int IW  = 32;
    localparam int LAT = c_IMEM_RD_LATENCY;

    logic          clk;
    logic          rst;
    logic          fe_ready;
    logic [AW-1:0] fe_addr;
    logic          fe_valid;
    logic [IW-1:0] fe_data;
    logic          fe_rvalid;
    logic [AW-1:0] fe_raddr;
    logic [IW-1:0] dec_instr;
    logic [AW-1:0] dec_pc;
    logic          dec_valid;
    logic          dec_ready;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          halt;
    logic          fetch_busy;

    fetch_stage #(
        .ADDR_W       (AW),
        .INSTR_W      (IW),
        .FIFO_DEPTH   (4),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fe_ready       (fe_ready),
        .fe_addr        (fe_addr),
        .fe_valid       (fe_valid),
        .fe_data        (fe_data),
        .fe_rvalid      (fe_rvalid),
        .fe_raddr       (fe_raddr),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt           (halt),
        .fetch_busy     (fetch_busy)
    );

    int            n_checks   = 0;
    int            n_fail     = 0;
    int            cyc        = 0;
    int            n_consumed = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_issue;
    logic          pv [LAT];
    logic [AW-1:0] pa [LAT];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_consumed(input int target, input string tag);
        for (int i = 0; i < 300 && n_consumed < target; i++) begin
            @(posedge clk); #1;
        end
        dec_ready = 1'b0;
        chk(tag, 32'(n_consumed), 32'(target));
    endtask

    task automatic wait_issue(input logic [AW-1:0] a, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (fe_valid && fe_addr == a) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic start_stream(input int n);
        n_consumed = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(AW'(i));
        exp_issue = '0;
        dec_ready = 1'b1;
        fe_ready  = 1'b1;
    endtask

    // Frontend: fixed-latency read pipe, flushed when it is not ready.
    initial begin
        fe_rvalid = 1'b0;
        fe_data   = '0;
        fe_raddr  = '0;
        for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pa[i] = '0; end
        forever begin
            @(negedge clk);
            if (rst || !fe_ready) begin
                for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
                fe_rvalid = 1'b0;
            end else begin
                fe_rvalid = pv[LAT-1];
                fe_raddr  = pa[LAT-1];
                fe_data   = instr_of(pa[LAT-1]);
                for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
                pv[0] = fe_valid;
                pa[0] = fe_addr;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && fe_valid) begin
                chk("fe_addr", 32'(fe_addr), 32'(exp_issue));
                exp_issue = exp_issue + AW'(1);
            end
        end
    end

    initial begin
        logic [AW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && dec_valid && dec_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    assert (exp_q.size() != 0) else begin
                        n_fail++;
                        $error("FAIL dec_extra: observed pc %h expected no entry", dec_pc);
                    end
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_pc", 32'(dec_pc), 32'(e));
                    chk("dec_instr", dec_instr, instr_of(e));
                end
                n_consumed++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_req;
        int first_dec;
        int gaps;
        rst            = 1'b1;
        fe_ready       = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        halt           = 1'b0;
        exp_issue      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_fe_valid",   32'(fe_valid),   32'd0);
        chk("rst_fe_addr",    32'(fe_addr),    32'd0);
        chk("rst_dec_valid",  32'(dec_valid),  32'd0);
        chk("rst_dec_instr",  dec_instr,       32'd0);
        chk("rst_dec_pc",     32'(dec_pc),     32'd0);
        chk("rst_fetch_busy", 32'(fetch_busy), 32'd0);

        // Basic stream: latency and gap-free delivery
        @(posedge clk); #1;
        first_req = -1;
        first_dec = -1;
        gaps      = 0;
        start_stream(16);
        for (int i = 0; i < 60 && n_consumed < 16; i++) begin
            @(negedge clk);
            if (fe_valid && first_req < 0) first_req = cyc;
            if (dec_valid && first_dec < 0) first_dec = cyc;
            if (first_dec >= 0 && !dec_valid) gaps++;
            @(posedge clk); #1;
        end
        dec_ready = 1'b0;
        chk("stream_count",   32'(n_consumed),          32'd16);
        chk("stream_latency", 32'(first_dec - first_req), 32'(LAT + 1));
        chk("stream_gaps",    32'(gaps),                32'd0);

        // Backpressure: credits exhausted, then resume in order
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_fe_valid",   32'(fe_valid),   32'd0);
        chk("bp_dec_valid",  32'(dec_valid),  32'd1);
        chk("bp_dec_pc",     32'(dec_pc),     32'd16);
        chk("bp_fetch_busy", 32'(fetch_busy), 32'd1);
        @(posedge clk); #1;
        n_consumed = 0;
        for (int i = 16; i < 32; i++) exp_q.push_back(AW'(i));
        dec_ready = 1'b1;
        wait_consumed(16, "bp_count");

        // Abort with reads in flight
        fe_ready = 1'b0;
        @(negedge clk);
        chk("abort_busy_before", 32'(fetch_busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("abort_dec_valid", 32'(dec_valid),  32'd0);
        chk("abort_busy",      32'(fetch_busy), 32'd0);

        // Redirect (with concurrent halt) while 5 and 6 are in flight
        @(posedge clk); #1;
        start_stream(5);
        wait_issue(AW'(6), "redir_seen_6");
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0040;
        halt           = 1'b1;
        exp_issue      = 16'h0040;
        for (int i = 0; i < 16; i++) exp_q.push_back(16'h0040 + AW'(i));
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        @(negedge clk);
        chk("redir_flushed",  32'(dec_valid), 32'd0);
        chk("redir_stay_run", 32'(fe_valid),  32'd1);
        wait_consumed(21, "redir_count");

        // Halt at pc 8 with two reads in flight
        fe_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start_stream(8);
        wait_issue(AW'(7), "halt_seen_7");
        @(posedge clk); #1;
        halt = 1'b1;
        @(negedge clk);
        chk("halt_no_issue", 32'(fe_valid),   32'd0);
        chk("halt_busy",     32'(fetch_busy), 32'd1);
        @(posedge clk); #1;
        halt = 1'b0;
        wait_consumed(8, "halt_count");
        repeat (3) begin
            @(negedge clk);
            chk("halt_hold", 32'(fe_valid), 32'd0);
        end
        chk("halt_drained", 32'(fetch_busy), 32'd0);
        @(posedge clk); #1;
        fe_ready = 1'b0;
        @(posedge clk); #1;

        // Restart from IDLE, then asynchronous reset mid-stream
        start_stream(64);
        repeat (8) @(posedge clk);
        #3;
        chk("pre_rst_fe_valid",  32'(fe_valid),  32'd1);
        chk("pre_rst_dec_valid", 32'(dec_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_fe_valid",   32'(fe_valid),   32'd0);
        chk("arst_dec_valid",  32'(dec_valid),  32'd0);
        chk("arst_fe_addr",    32'(fe_addr),    32'd0);
        chk("arst_fetch_busy", 32'(fetch_busy), 32'd0);
        fe_ready  = 1'b0;
        dec_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fe_valid", 32'(fe_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Sits directly downstream of the instruction frontend (IMEM/maintenance mux) and upstream of decode.
- Generates sequential instruction addresses toward the frontend and tracks in-flight reads.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects (jumps/branches) from decode by discarding stale in-flight responses, and stops fetching on a halt request.

Parameters:
- ADDR_W, `IMEM_ADDR_WIDTH: instruction address width.
- INSTR_W, `INSTR_WIDTH: instruction word width.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, at least 2.
- MAX_INFLIGHT, 4: outstanding-read limit; must be at least `IMEM_RD_LATENCY for full throughput.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- fe_ready  in  1  frontend accepts requests (frontend ready_in).
- fe_addr  out  ADDR_W  read address (to frontend addr_in).
- fe_valid  out  1  read request (to frontend valid_in).
- fe_data  in  INSTR_W  returned instruction (frontend data_out).
- fe_rvalid  in  1  response valid (frontend valid_out).
- fe_raddr  in  ADDR_W  response address (frontend addr_out); used for debug only.
- dec_instr  out  INSTR_W  instruction to decode.
- dec_pc  out  ADDR_W  address of dec_instr.
- dec_valid  out  1  dec_instr valid.
- dec_ready  in  1  decode consumes the head entry when dec_valid & dec_ready.
- redirect_valid  in  1  decode requests a fetch redirect.
- redirect_addr  in  ADDR_W  redirect target.
- halt  in  1  END instruction decoded; stop fetching.
- fetch_busy  out  1  in-flight count or FIFO occupancy is nonzero.

Behaviour:
- Reset (async, active-high): state IDLE; pc=0; inflight=0; drop_cnt=0; FIFO empty.
- Reset output values: fe_valid=0, fe_addr=0, dec_valid=0, dec_instr=0, dec_pc=0, fetch_busy=0.
- States:
  - IDLE: fe_valid=0. Go to RUN when fe_ready=1; pc is cleared to 0 on that transition.
  - RUN: issue requests. On halt, go to HALT. If fe_ready=0, go to IDLE and clear FIFO, inflight and drop_cnt (program aborted or reset by the frontend).
  - HALT: fe_valid=0. In-flight responses still drain into the FIFO. Go to IDLE when fe_ready=0.
- Issue rule:
  - fe_valid = (state==RUN) & fe_ready & ~halt & ~redirect_valid & (inflight + fifo_count < FIFO_DEPTH) & (inflight < MAX_INFLIGHT).
  - fe_addr = pc, combinational from the register.
  - Each issuing cycle: pc <= pc+1, wrapping modulo 2^ADDR_W; inflight increments.
- Response rule:
  - On fe_rvalid, inflight decrements. Concurrent issue and response leaves inflight unchanged.
  - If drop_cnt>0, drop_cnt decrements and the data is discarded.
  - Otherwise push {fe_data, tracked address} into the FIFO. The tracked address is a resp_pc register, advanced on every push and loaded with redirect_addr on a redirect.
  - The credit check guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- Redirect (takes priority over issue in the same cycle):
  - pc <= redirect_addr; resp_pc <= redirect_addr; FIFO flushed.
  - drop_cnt <= inflight - (fe_rvalid ? 1 : 0) + drop_cnt_adjust, so that every read issued before the redirect is discarded.
  - First new request is issued the next cycle.
  - A redirect together with a dec_ready handshake: the handshake completes and the entry is consumed, then the flush applies.
- Halt and redirect in the same cycle: redirect wins, state stays RUN.
- FIFO output:
  - dec_valid = ~empty; dec_instr/dec_pc show the head entry (first-word fall-through).
  - Push to an empty FIFO is visible the next cycle.
  - Simultaneous push and pop when full is legal.
- Latency:
  - Request to dec_valid = `IMEM_RD_LATENCY + 1 cycles.
  - Sustained throughput of 1 instruction/cycle with dec_ready held high.
- fetch_busy = (inflight!=0) | ~empty.

Decomposition:
- Shared package/header (parameters.vh): state encodings FETCH_IDLE/RUN/HALT, plus the `IMEM_ADDR_WIDTH, `INSTR_WIDTH and `IMEM_RD_LATENCY defines.
- Sub-module: fetch_fifo.
  - Synchronous FWFT FIFO, width INSTR_W+ADDR_W, depth FIFO_DEPTH, with flush input.
  - Ports: push, pop, full, empty, count.

Test Plan:
- Basic stream: fe_ready rises, latency 2, dec_ready=1 → fe_addr 0,1,2,… one per cycle; dec_pc sequence 0,1,2 starts 3 cycles after the first request; no gaps.
- Backpressure: dec_ready=0 for 20 cycles → fe_valid deasserts once inflight+count=4. Release → no instruction lost or duplicated; order preserved.
- Redirect with 2 reads in flight (addresses 5,6), redirect_addr=0x40 → responses 5,6 dropped; FIFO flushed; next dec_pc=0x40, then 0x41.
- Halt at pc=8 with 2 in flight → no further requests; the 2 responses enter the FIFO; state HALT; fe_ready drop → IDLE; fetch_busy falls after drain.
- Abort: fe_ready falls mid-RUN with 3 in flight → FIFO cleared, inflight=0, dec_valid=0 next cycle. Re-raise → fetch restarts at 0.
- Async reset asserted mid-stream, between clock edges → dec_valid and fe_valid go 0 immediately, without waiting for a clock edge; pc=0.
